// File: rtl/pc_fetch_stage.sv
// IF stage: program counter, next-PC selection with predict-taken branches,
// IF/ID pipeline register with flush/stall, and saturating branch counters.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [1:0]       Branch,
    input  logic             IF_flush,
    input  logic [1:0]       Jump,
    input  logic [31:0]      instr_if,
    input  logic [31:0]      rf_rd1,
    output logic [31:0]      pc_if,
    output logic [31:0]      instr_id,
    output logic [31:0]      pc4_id,
    output logic             valid_id,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_id_q, instr_id_d;
    logic [31:0]      pc4_id_q, pc4_id_d;
    logic             valid_id_q, valid_id_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [31:0] pc4_if;
    logic [31:0] bt_if;
    logic        redirect;
    logic        flush;

    always_comb begin
        pc4_if   = pc_q + 32'd4;
        bt_if    = pc4_if + {{14{instr_if[15]}}, instr_if[15:0], 2'b00};
        redirect = (Branch == 2'b10) || (Jump != 2'b00);
        flush    = redirect || IF_flush;

        pc_d          = pc_q;
        instr_id_d    = instr_id_q;
        pc4_id_d      = pc4_id_q;
        valid_id_d    = valid_id_q;
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        // A stall freezes everything; control re-evaluates once the stall drops.
        if (!stall) begin
            if (Branch == 2'b10)
                pc_d = pc4_id_q;
            else if (Jump == 2'b01)
                pc_d = {pc4_id_q[31:28], instr_id_q[25:0], 2'b00};
            else if (Jump == 2'b10)
                pc_d = rf_rd1;
            else if (Branch == 2'b01)
                pc_d = bt_if;
            else
                pc_d = pc4_if;

            if (flush) begin
                instr_id_d = '0;
                pc4_id_d   = '0;
                valid_id_d = 1'b0;
            end else begin
                instr_id_d = instr_if;
                pc4_id_d   = pc4_if;
                valid_id_d = 1'b1;
            end

            if ((Branch == 2'b01) && !flush && (br_cnt_q != '1))
                br_cnt_d = br_cnt_q + CNT_W'(1);
            if ((Branch == 2'b10) && (mispred_cnt_q != '1))
                mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            instr_id_q    <= '0;
            pc4_id_q      <= '0;
            valid_id_q    <= 1'b0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            pc_q          <= pc_d;
            instr_id_q    <= instr_id_d;
            pc4_id_q      <= pc4_id_d;
            valid_id_q    <= valid_id_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pc_if       = pc_q;
    assign instr_id    = instr_id_q;
    assign pc4_id      = pc4_id_q;
    assign valid_id    = valid_id_q;
    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Scoreboard bench for pc_fetch_stage: directed steps queue the expected
// post-edge state; a monitor pops and compares one entry after each rising edge.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  Branch;
    logic        IF_flush;
    logic [1:0]  Jump;
    logic [31:0] instr_if;
    logic [31:0] rf_rd1;
    logic [31:0] pc_if;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic        valid_id;
    logic [3:0]  br_cnt;
    logic [3:0]  mispred_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] pc4;
        logic        v;
        logic [3:0]  br;
        logic [3:0]  mp;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    pc_fetch_stage #(.RESET_PC(32'h0000_3000), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .Branch(Branch), .IF_flush(IF_flush),
        .Jump(Jump), .instr_if(instr_if), .rf_rd1(rf_rd1), .pc_if(pc_if),
        .instr_id(instr_id), .pc4_id(pc4_id), .valid_id(valid_id),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s.%s got=%h exp=%h", nm, fld, act, expv);
        end
    endtask

    // Monitor: one scoreboard entry per rising edge, sampled 1ns after it.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk(nm, "pc_if",       pc_if,              e.pc);
                chk(nm, "instr_id",    instr_id,           e.ins);
                chk(nm, "pc4_id",      pc4_id,             e.pc4);
                chk(nm, "valid_id",    {31'd0, valid_id},  {31'd0, e.v});
                chk(nm, "br_cnt",      {28'd0, br_cnt},    {28'd0, e.br});
                chk(nm, "mispred_cnt", {28'd0, mispred_cnt}, {28'd0, e.mp});
            end
        end
    end

    task automatic step(input string nm, input logic r, input bit pulse,
                        input logic st, input logic [1:0] br, input logic fl,
                        input logic [1:0] jp, input logic [31:0] ins, input logic [31:0] rd1,
                        input logic [31:0] e_pc, input logic [31:0] e_ins,
                        input logic [31:0] e_pc4, input logic e_v,
                        input logic [3:0] e_br, input logic [3:0] e_mp);
        exp_t e;
        @(negedge clk);
        rst = r; stall = st; Branch = br; IF_flush = fl; Jump = jp;
        instr_if = ins; rf_rd1 = rd1;
        e.pc = e_pc; e.ins = e_ins; e.pc4 = e_pc4; e.v = e_v; e.br = e_br; e.mp = e_mp;
        exp_q.push_back(e);
        name_q.push_back(nm);
        // Short reset pulse that never overlaps a clock edge.
        if (pulse) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pcb;
        rst = 1'b1; stall = 1'b0; Branch = 2'b00; IF_flush = 1'b0; Jump = 2'b00;
        instr_if = '0; rf_rd1 = '0;
        repeat (2) @(posedge clk);

        step("reset",    1, 0, 0, 2'b00, 0, 2'b00, 32'h2000_0000, 0, 32'h3000, 0, 0, 0, 0, 0);
        step("seq0",     0, 0, 0, 2'b00, 0, 2'b00, 32'h2000_0000, 0, 32'h3004, 32'h2000_0000, 32'h3004, 1, 0, 0);
        step("seq1",     0, 0, 0, 2'b00, 0, 2'b00, 32'h2000_0004, 0, 32'h3008, 32'h2000_0004, 32'h3008, 1, 0, 0);
        step("seq2",     0, 0, 0, 2'b00, 0, 2'b00, 32'h2000_0008, 0, 32'h300C, 32'h2000_0008, 32'h300C, 1, 0, 0);
        step("seq3",     0, 0, 0, 2'b00, 0, 2'b00, 32'h2000_000C, 0, 32'h3010, 32'h2000_000C, 32'h3010, 1, 0, 0);
        step("predict",  0, 0, 0, 2'b01, 0, 2'b00, 32'h1000_0004, 0, 32'h3024, 32'h1000_0004, 32'h3014, 1, 1, 0);
        step("mispred",  0, 0, 0, 2'b10, 1, 2'b00, 32'h2000_0024, 0, 32'h3014, 0, 0, 0, 1, 1);
        step("refetch",  0, 0, 0, 2'b00, 0, 2'b00, 32'h2000_0014, 0, 32'h3018, 32'h2000_0014, 32'h3018, 1, 1, 1);
        step("rst_async",0, 1, 0, 2'b00, 0, 2'b00, 32'h2000_3000, 0, 32'h3004, 32'h2000_3000, 32'h3004, 1, 0, 0);
        step("pred_fwd", 0, 0, 0, 2'b01, 0, 2'b00, 32'h1000_0009, 0, 32'h302C, 32'h1000_0009, 32'h3008, 1, 1, 0);
        step("fetch_j",  0, 0, 0, 2'b00, 0, 2'b00, 32'h0800_0C10, 0, 32'h3030, 32'h0800_0C10, 32'h3030, 1, 1, 0);
        step("jump",     0, 0, 0, 2'b00, 0, 2'b01, 32'h2000_3030, 0, 32'h3040, 0, 0, 0, 1, 0);
        step("fetch_jr", 0, 0, 0, 2'b00, 0, 2'b00, 32'h0000_0008, 0, 32'h3044, 32'h0000_0008, 32'h3044, 1, 1, 0);
        step("jr_prio",  0, 0, 0, 2'b01, 0, 2'b10, 32'h1000_0004, 32'h3100, 32'h3100, 0, 0, 0, 1, 0);
        step("if_flush", 0, 0, 0, 2'b00, 1, 2'b00, 32'h2000_3100, 0, 32'h3104, 0, 0, 0, 1, 0);
        step("seq4",     0, 0, 0, 2'b00, 0, 2'b00, 32'h2000_3104, 0, 32'h3108, 32'h2000_3104, 32'h3108, 1, 1, 0);
        step("stall0",   0, 0, 1, 2'b10, 1, 2'b00, 32'h2000_3108, 0, 32'h3108, 32'h2000_3104, 32'h3108, 1, 1, 0);
        step("stall1",   0, 0, 1, 2'b10, 1, 2'b00, 32'h2000_3108, 0, 32'h3108, 32'h2000_3104, 32'h3108, 1, 1, 0);
        step("stall2",   0, 0, 1, 2'b10, 1, 2'b00, 32'h2000_3108, 0, 32'h3108, 32'h2000_3104, 32'h3108, 1, 1, 0);
        step("stall3",   0, 0, 1, 2'b01, 0, 2'b10, 32'h1000_0004, 32'hDEAD_0000, 32'h3108, 32'h2000_3104, 32'h3108, 1, 1, 0);
        step("unstall",  0, 0, 0, 2'b10, 1, 2'b00, 32'h2000_3108, 0, 32'h3108, 0, 0, 0, 1, 1);
        step("misalign", 0, 0, 0, 2'b00, 0, 2'b10, 32'h2000_3108, 32'h5003, 32'h5003, 0, 0, 0, 1, 1);

        for (int i = 0; i < 17; i++) begin
            pcb = 32'h5003 + 32'(4 * i);
            step("br_sat", 0, 0, 0, 2'b01, 0, 2'b00, 32'h1000_0000, 0, pcb + 32'd4,
                 32'h1000_0000, pcb + 32'd4, 1, (i + 2 > 15) ? 4'hF : 4'(i + 2), 1);
        end
        for (int i = 0; i < 15; i++) begin
            step("mp_sat", 0, 0, 0, 2'b10, 1, 2'b00, 0, 0, (i == 0) ? 32'h5047 : 32'h0,
                 0, 0, 0, 4'hF, (i + 2 > 15) ? 4'hF : 4'(i + 2));
        end

        step("to_top",   0, 0, 0, 2'b00, 0, 2'b10, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0, 4'hF, 4'hF);
        step("wrap",     0, 0, 0, 2'b01, 0, 2'b00, 32'h1000_0001, 0, 32'h0000_0004, 32'h1000_0001, 32'h0, 1, 4'hF, 4'hF);
        step("seq5",     0, 0, 0, 2'b00, 0, 2'b00, 32'h2000_0004, 0, 32'h8, 32'h2000_0004, 32'h8, 1, 4'hF, 4'hF);
        step("neg_off",  0, 0, 0, 2'b01, 0, 2'b00, 32'h1000_FFFE, 0, 32'h4, 32'h1000_FFFE, 32'hC, 1, 4'hF, 4'hF);
        step("jr_high",  0, 0, 0, 2'b00, 0, 2'b10, 0, 32'h7000_0000, 32'h7000_0000, 0, 0, 0, 4'hF, 4'hF);
        step("fetch_j2", 0, 0, 0, 2'b00, 0, 2'b00, 32'h0800_0100, 0, 32'h7000_0004, 32'h0800_0100, 32'h7000_0004, 1, 4'hF, 4'hF);
        step("j_region", 0, 0, 0, 2'b00, 0, 2'b01, 0, 0, 32'h7000_0400, 0, 0, 0, 4'hF, 4'hF);
        step("fetch_j3", 0, 0, 0, 2'b00, 0, 2'b00, 32'h0800_0100, 0, 32'h7000_0404, 32'h0800_0100, 32'h7000_0404, 1, 4'hF, 4'hF);
        step("br_vs_j",  0, 0, 0, 2'b10, 0, 2'b01, 0, 0, 32'h7000_0404, 0, 0, 0, 4'hF, 4'hF);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
